// File: rtl/cache_types_pkg.sv
// cache_types_pkg
//   Shared types for the L1 cache controller slice.
//   - cache_state_t : controller states CHECK / WB / FILL
//   - NUM_WAYS      : associativity (2)
//   - hit_index()   : encodes a per-way hit vector into a way index
//   Optional feature macro used elsewhere in this slice: CACHE_PERF_CNT_EN.
package cache_types_pkg;

  localparam int NUM_WAYS = 2;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2
  } cache_state_t;

  // Way index of a hit vector; the illegal double hit 2'b11 resolves to way 0.
  function automatic logic hit_index(input logic [NUM_WAYS-1:0] hit);
    return hit[1] & ~hit[0];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if
//   Bundles the CPU handshake, metadata inputs, array write controls and
//   physical-memory handshake of the cache controller.
//   Modports:
//   - slave  : the controller (consumes requests/metadata, drives controls)
//   - master : CPU + datapath + memory side (the opposite directions)
interface cache_ctrl_if;
  import cache_types_pkg::*;

  // CPU side
  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  // metadata of the addressed set
  logic [NUM_WAYS-1:0] hit_way;
  logic [NUM_WAYS-1:0] dirty_way;
  logic                lru_way;
  // array write controls and datapath selects
  logic [NUM_WAYS-1:0] data_we;
  logic                data_sel_mem;
  logic [NUM_WAYS-1:0] tag_we;
  logic [NUM_WAYS-1:0] valid_we;
  logic [NUM_WAYS-1:0] dirty_we;
  logic                dirty_din;
  logic                lru_we;
  logic                lru_din;
  logic                out_way;
  // physical-memory side
  logic                pmem_addr_sel;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;

  modport slave (
    input  mem_read, mem_write, hit_way, dirty_way, lru_way, pmem_resp,
    output mem_resp, data_we, data_sel_mem, tag_we, valid_we, dirty_we,
           dirty_din, lru_we, lru_din, out_way, pmem_addr_sel, pmem_read,
           pmem_write
  );

  modport master (
    output mem_read, mem_write, hit_way, dirty_way, lru_way, pmem_resp,
    input  mem_resp, data_we, data_sel_mem, tag_we, valid_we, dirty_we,
           dirty_din, lru_we, lru_din, out_way, pmem_addr_sel, pmem_read,
           pmem_write
  );

endinterface

// File: rtl/cache_perf_ctr.sv
// cache_perf_ctr
//   Single saturating event counter (used only when CACHE_PERF_CNT_EN is defined).
//   Ports: clk, rst (sync, active-high), inc (count enable), count (value).
module cache_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Counter register: clears on reset, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl
//   Control FSM of the 2-way set-associative, write-back, write-allocate L1.
//   Ports:
//   - clk, rst : clock and synchronous active-high reset
//   - bus      : cache_ctrl_if.slave (CPU handshake, set metadata, array
//                write enables / muxes, pmem handshake)
//   - hit_cnt, miss_cnt, wb_cnt : performance counters, present only when
//                the macro CACHE_PERF_CNT_EN is defined
//   Hits complete in the request cycle; misses write back a dirty victim,
//   fill the line, then replay the request as a hit.
module cache_ctrl
  import cache_types_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_ctrl_if.slave      bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
`endif
);

  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_WB    = WB;
  localparam logic [1:0] ST_FILL  = FILL;

  logic [1:0]          state_q, state_d;
  logic                victim_q, victim_d;

  logic                req_s;
  logic                hw_s;
  logic                mem_resp_s;
  logic [NUM_WAYS-1:0] data_we_s, tag_we_s, valid_we_s, dirty_we_s;
  logic                data_sel_mem_s, dirty_din_s, lru_we_s, lru_din_s;
  logic                out_way_s, pmem_addr_sel_s, pmem_read_s, pmem_write_s;

  assign req_s = bus.mem_read | bus.mem_write;
  assign hw_s  = hit_index(bus.hit_way);

  // State and victim registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next state and all control outputs; everything defaults to 0 / hold.
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    mem_resp_s      = 1'b0;
    data_we_s       = 2'b00;
    data_sel_mem_s  = 1'b0;
    tag_we_s        = 2'b00;
    valid_we_s      = 2'b00;
    dirty_we_s      = 2'b00;
    dirty_din_s     = 1'b0;
    lru_we_s        = 1'b0;
    lru_din_s       = 1'b0;
    out_way_s       = 1'b0;
    pmem_addr_sel_s = 1'b0;
    pmem_read_s     = 1'b0;
    pmem_write_s    = 1'b0;
    case (state_q)
      ST_CHECK: begin
        if (req_s && (bus.hit_way != 2'b00)) begin
          mem_resp_s = 1'b1;
          out_way_s  = hw_s;
          lru_we_s   = 1'b1;
          lru_din_s  = ~hw_s;
          // a write (including read+write together) merges CPU data and marks dirty
          if (bus.mem_write) begin
            data_we_s[hw_s]  = 1'b1;
            dirty_we_s[hw_s] = 1'b1;
            dirty_din_s      = 1'b1;
          end else begin
            data_we_s = 2'b00;
          end
        end else if (req_s) begin
          victim_d = bus.lru_way;
          if (bus.dirty_way[bus.lru_way]) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_WB: begin
        pmem_write_s    = 1'b1;
        pmem_addr_sel_s = 1'b1;
        if (bus.pmem_resp) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_FILL: begin
        pmem_read_s = 1'b1;
        // the line lands in the victim way as a clean, valid line
        if (bus.pmem_resp) begin
          data_we_s[victim_q]  = 1'b1;
          tag_we_s[victim_q]   = 1'b1;
          valid_we_s[victim_q] = 1'b1;
          dirty_we_s[victim_q] = 1'b1;
          data_sel_mem_s       = 1'b1;
          dirty_din_s          = 1'b0;
          state_d              = ST_CHECK;
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_CHECK;
      end
    endcase
  end

  assign bus.mem_resp      = mem_resp_s;
  assign bus.data_we       = data_we_s;
  assign bus.data_sel_mem  = data_sel_mem_s;
  assign bus.tag_we        = tag_we_s;
  assign bus.valid_we      = valid_we_s;
  assign bus.dirty_we      = dirty_we_s;
  assign bus.dirty_din     = dirty_din_s;
  assign bus.lru_we        = lru_we_s;
  assign bus.lru_din       = lru_din_s;
  assign bus.out_way       = out_way_s;
  assign bus.pmem_addr_sel = pmem_addr_sel_s;
  assign bus.pmem_read     = pmem_read_s;
  assign bus.pmem_write    = pmem_write_s;

`ifdef CACHE_PERF_CNT_EN
  logic replay_q;
  logic hit_inc_s, miss_inc_s, wb_inc_s;

  // Marks the first CHECK cycle after a fill, whose hit is the miss replay.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q <= 1'b0;
    end else begin
      replay_q <= (state_q == ST_FILL) && bus.pmem_resp;
    end
  end

  assign hit_inc_s  = (state_q == ST_CHECK) && req_s && (bus.hit_way != 2'b00) && !replay_q;
  assign miss_inc_s = (state_q == ST_CHECK) && req_s && (bus.hit_way == 2'b00);
  assign wb_inc_s   = (state_q == ST_WB) && bus.pmem_resp;

  cache_perf_ctr #(.CNT_W(CNT_W)) u_hit_ctr  (.clk(clk), .rst(rst), .inc(hit_inc_s),  .count(hit_cnt));
  cache_perf_ctr #(.CNT_W(CNT_W)) u_miss_ctr (.clk(clk), .rst(rst), .inc(miss_inc_s), .count(miss_cnt));
  cache_perf_ctr #(.CNT_W(CNT_W)) u_wb_ctr   (.clk(clk), .rst(rst), .inc(wb_inc_s),   .count(wb_cnt));
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
//   Self-checking bench for cache_ctrl. A transaction-level model of a small
//   2-way cache (valid/tag/dirty/LRU per set) supplies the metadata inputs and
//   predicts the full output vector for every cycle of each request; a single
//   negedge process compares the DUT against those predictions. A few
//   directed cases pin the model with hand-computed literals.
`timescale 1ns/1ps
module tb_cache_ctrl;
  import cache_types_pkg::*;

  typedef struct packed {
    logic       resp;
    logic [1:0] data_we;
    logic       sel_mem;
    logic [1:0] tag_we;
    logic [1:0] valid_we;
    logic [1:0] dirty_we;
    logic       dirty_din;
    logic       lru_we;
    logic       lru_din;
    logic       out_way;
    logic       addr_sel;
    logic       pread;
    logic       pwrite;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if bus();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_ctrl #(.S_INDEX(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  outs_t exp_q[$];
  string lbl_q[$];

  // monitor statistics used by the literal checks
  int         pread_cyc = 0;
  int         pwrite_cyc = 0;
  int         resp_cnt = 0;
  logic [1:0] fill_we_seen = 2'b00;
  logic [1:0] resp_dirty_we_seen = 2'b00;

  // cache model
  bit [1:0] m_valid [16];
  bit [1:0] m_dirty [16];
  bit [3:0] m_tag   [16][2];
  bit       m_lru   [16];
  int       m_hits = 0, m_misses = 0, m_wbs = 0;

  function automatic outs_t snap();
    outs_t a;
    a.resp      = bus.mem_resp;
    a.data_we   = bus.data_we;
    a.sel_mem   = bus.data_sel_mem;
    a.tag_we    = bus.tag_we;
    a.valid_we  = bus.valid_we;
    a.dirty_we  = bus.dirty_we;
    a.dirty_din = bus.dirty_din;
    a.lru_we    = bus.lru_we;
    a.lru_din   = bus.lru_din;
    a.out_way   = bus.out_way;
    a.addr_sel  = bus.pmem_addr_sel;
    a.pread     = bus.pmem_read;
    a.pwrite    = bus.pmem_write;
    return a;
  endfunction

  // Compare process: one predicted output vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    string l;
    a = snap();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s at %0t: got %h expected %h", l, $time, a, e);
      end
    end
    if (a.pread) pread_cyc++;
    if (a.pwrite) pwrite_cyc++;
    if (a.resp) begin
      resp_cnt++;
      resp_dirty_we_seen = a.dirty_we;
    end
    if (a.pread && bus.pmem_resp) fill_we_seen = a.data_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input outs_t e, input string l);
    exp_q.push_back(e);
    lbl_q.push_back(l);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    pread_cyc = 0; pwrite_cyc = 0; resp_cnt = 0;
    fill_we_seen = 2'b00; resp_dirty_we_seen = 2'b00;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 2'b00; m_dirty[i] = 2'b00; m_lru[i] = 1'b0;
      m_tag[i][0] = 4'd0; m_tag[i][1] = 4'd0;
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endtask

  task automatic idle_inputs();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit_way = 2'b00;
    bus.dirty_way = 2'b00; bus.lru_way = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  function automatic bit [1:0] hits(input int idx, input bit [3:0] tg);
    bit [1:0] h;
    for (int w = 0; w < 2; w++) h[w] = m_valid[idx][w] && (m_tag[idx][w] == tg);
    return h;
  endfunction

  // One CPU request, driven to completion, with per-cycle predictions.
  task automatic do_req(input int idx, input bit [3:0] tg, input bit wr, input bit rd,
                        input int wb_lat, input int fill_lat);
    bit [1:0] h;
    bit       hw;
    bit       v;
    bit       replay;
    outs_t    e;
    replay = 1'b0;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    for (int pass = 0; pass < 2; pass++) begin
      h = hits(idx, tg);
      bus.hit_way   = h;
      bus.dirty_way = m_dirty[idx];
      bus.lru_way   = m_lru[idx];
      if (h != 2'b00) begin
        hw = (h == 2'b10);
        e = '0;
        e.resp = 1'b1; e.out_way = hw; e.lru_we = 1'b1; e.lru_din = ~hw;
        if (wr) begin
          e.data_we[hw] = 1'b1; e.dirty_we[hw] = 1'b1; e.dirty_din = 1'b1;
          m_dirty[idx][hw] = 1'b1;
        end
        m_lru[idx] = ~hw;
        if (!replay) m_hits++;
        step(e, replay ? "replay_hit" : "hit");
        break;
      end
      v = m_lru[idx];
      m_misses++;
      step(outs_t'(0), "miss_detect");
      if (m_dirty[idx][v]) begin
        m_wbs++;
        for (int k = 1; k <= wb_lat; k++) begin
          bus.pmem_resp = (k == wb_lat);
          e = '0; e.pwrite = 1'b1; e.addr_sel = 1'b1;
          step(e, "writeback");
        end
      end
      for (int k = 1; k <= fill_lat; k++) begin
        bus.pmem_resp = (k == fill_lat);
        e = '0; e.pread = 1'b1;
        if (k == fill_lat) begin
          e.data_we[v] = 1'b1; e.tag_we[v] = 1'b1; e.valid_we[v] = 1'b1;
          e.dirty_we[v] = 1'b1; e.sel_mem = 1'b1;
        end
        step(e, "fill");
      end
      bus.pmem_resp = 1'b0;
      m_valid[idx][v] = 1'b1; m_tag[idx][v] = tg; m_dirty[idx][v] = 1'b0;
      replay = 1'b1;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  initial begin
    outs_t e;
    int    r;
    idle_inputs();
    clear_model();
    rst = 1'b1;
    @(posedge clk); #1;
    step(outs_t'(0), "reset_state");
    rst = 1'b0;
    step(outs_t'(0), "idle_after_reset");

    // read hit in way 1
    bus.mem_read = 1'b1; bus.hit_way = 2'b10;
    #1;
    check("rd_hit_resp", bus.mem_resp, 32'd1);
    check("rd_hit_out_way", bus.out_way, 32'd1);
    check("rd_hit_lru_we", bus.lru_we, 32'd1);
    check("rd_hit_lru_din", bus.lru_din, 32'd0);
    check("rd_hit_data_we", bus.data_we, 32'd0);
    @(posedge clk); #1;

    // write hit in way 0
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.hit_way = 2'b01;
    #1;
    check("wr_hit_data_we", bus.data_we, 32'd1);
    check("wr_hit_dirty_we", bus.dirty_we, 32'd1);
    check("wr_hit_dirty_din", bus.dirty_din, 32'd1);
    check("wr_hit_resp", bus.mem_resp, 32'd1);
    check("wr_hit_lru_din", bus.lru_din, 32'd1);
    @(posedge clk); #1;

    // illegal double hit resolves to way 0
    bus.mem_write = 1'b0; bus.mem_read = 1'b1; bus.hit_way = 2'b11;
    #1;
    check("dbl_hit_out_way", bus.out_way, 32'd0);
    check("dbl_hit_lru_din", bus.lru_din, 32'd1);
    @(posedge clk); #1;
    idle_inputs();

    // clean read miss, victim way 1, fill takes 5 cycles
    m_lru[1] = 1'b1;
    clear_stats();
    do_req(1, 4'd3, 1'b0, 1'b1, 1, 5);
    step(outs_t'(0), "idle");
    check("clean_miss_pread_cycles", pread_cyc, 32'd5);
    check("clean_miss_pwrite_cycles", pwrite_cyc, 32'd0);
    check("clean_miss_fill_we", fill_we_seen, 32'd2);
    check("clean_miss_resp_count", resp_cnt, 32'd1);

    // dirty write miss, victim way 0
    m_valid[2] = 2'b01; m_tag[2][0] = 4'd1; m_dirty[2] = 2'b01; m_lru[2] = 1'b0;
    clear_stats();
    do_req(2, 4'd7, 1'b1, 1'b0, 3, 2);
    step(outs_t'(0), "idle");
    check("dirty_miss_pwrite_cycles", pwrite_cyc, 32'd3);
    check("dirty_miss_pread_cycles", pread_cyc, 32'd2);
    check("dirty_miss_replay_dirty_we", resp_dirty_we_seen, 32'd1);

    // reset in the 2nd FILL cycle abandons the transfer
    bus.mem_read = 1'b1; bus.hit_way = 2'b00; bus.dirty_way = 2'b00; bus.lru_way = 1'b0;
    step(outs_t'(0), "rf_miss");
    e = '0; e.pread = 1'b1;
    step(e, "rf_fill1");
    rst = 1'b1;
    step(e, "rf_fill2_rst");
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rf_pread_dropped", bus.pmem_read, 32'd0);
    step(outs_t'(0), "rf_after_reset");
    bus.pmem_resp = 1'b1;
    step(outs_t'(0), "rf_stray_pmem_resp");
    bus.pmem_resp = 1'b0;
    step(outs_t'(0), "rf_idle");
    clear_model();

    // 3 hits, 1 clean miss, 1 dirty miss since the reset
    m_valid[4] = 2'b01; m_tag[4][0] = 4'd1;
    m_valid[6] = 2'b11; m_tag[6][0] = 4'd2; m_tag[6][1] = 4'd3;
    m_dirty[6] = 2'b10; m_lru[6] = 1'b1;
    for (int i = 0; i < 3; i++) do_req(4, 4'd1, 1'b0, 1'b1, 1, 1);
    do_req(5, 4'd9, 1'b0, 1'b1, 1, 2);
    do_req(6, 4'd5, 1'b1, 1'b0, 2, 2);
    step(outs_t'(0), "idle");
`ifdef CACHE_PERF_CNT_EN
    check("perf_hit_cnt", hit_cnt, 32'd3);
    check("perf_miss_cnt", miss_cnt, 32'd2);
    check("perf_wb_cnt", wb_cnt, 32'd1);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) step(outs_t'(0), "rand_idle");
      r = $urandom_range(0, 2);
      do_req($urandom_range(0, 15), 4'($urandom_range(0, 3)), (r != 0), (r != 1),
             $urandom_range(1, 4), $urandom_range(1, 4));
    end
    step(outs_t'(0), "final_idle");
`ifdef CACHE_PERF_CNT_EN
    check("perf_hit_model", hit_cnt, m_hits);
    check("perf_miss_model", miss_cnt, m_misses);
    check("perf_wb_model", wb_cnt, m_wbs);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache. It reads the per-set metadata produced by the cache datapath and drives every array write enable and datapath mux select. Metadata comes from the valid, dirty, tag and LRU flip-flop arrays, which have asynchronous read and synchronous write. It also sequences victim writeback and line fill over the physical-memory port, and returns `mem_resp` to the CPU.

## Interface
- `S_INDEX`, 4, set-index width; must match the metadata arrays.
- `CNT_W`, 32, width of performance counters; used only with `CACHE_PERF_CNT_EN`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `mem_resp`  out  1  request complete; one-cycle pulse.
- `hit_way`  in  2  per-way (valid & tag match) for the addressed set.
- `dirty_way`  in  2  per-way dirty bits for the addressed set.
- `lru_way`  in  1  least-recently-used way index of the set.
- `data_we`  out  2  per-way data-line write enable.
- `data_sel_mem`  out  1  1 = line data from pmem; 0 = CPU write data merged by byte enable.
- `tag_we`, `valid_we`  out  2 each  per-way tag/valid write enable; valid din is tied 1 in the datapath.
- `dirty_we`  out  2  per-way dirty write enable.
- `dirty_din`  out  1  dirty value written.
- `lru_we`  out  1  LRU array write enable.
- `lru_din`  out  1  new LRU way index.
- `out_way`  out  1  way steering CPU read data.
- `pmem_addr_sel`  out  1  1 = victim {tag, index}; 0 = miss address.
- `pmem_read`, `pmem_write`  out  1 each  memory requests, level until `pmem_resp`.
- `pmem_resp`  in  1  memory transfer complete; one-cycle pulse.

## Operation
- States: CHECK (reset state), WB, FILL.
- All outputs are 0 in reset and in CHECK with no request.
- Request `req = mem_read | mem_write`. If both are asserted, this is treated as a write.
- **CHECK, hit** (`|hit_way`): `hw` = index of the set bit.
  - Assert `mem_resp` combinationally in the same cycle.
  - `out_way = hw`, `lru_we = 1`, `lru_din = ~hw`.
  - On a write, also assert `data_we[hw]` (`data_sel_mem = 0`), `dirty_we[hw]` and `dirty_din = 1`.
  - Stay in CHECK.
- **CHECK, miss**: victim `v = lru_way`.
  - If `dirty_way[v]`, go to WB; otherwise go to FILL.
  - Victim selection is latched into a `victim` register on this transition.
- **WB**:
  - Assert `pmem_write` with `pmem_addr_sel = 1`.
  - On `pmem_resp`, go to FILL.
  - Array write enables are all 0.
- **FILL**:
  - Assert `pmem_read` with `pmem_addr_sel = 0`.
  - On `pmem_resp`, in the same cycle, assert `data_we[victim]`, `tag_we[victim]` and `valid_we[victim]` with `data_sel_mem = 1`.
  - Also assert `dirty_we[victim]` with `dirty_din = 0`, then go to CHECK.
- After FILL the request re-evaluates in CHECK and hits, so the hit path performs the write merge, the dirty set and the LRU update.
- `mem_resp` is never asserted in WB or FILL.
- A request withdrawn mid-miss is illegal CPU behaviour; the controller still completes WB/FILL.
- An illegal `hit_way = 2'b11` resolves to way 0.

## Timing
- Hit latency: 0 cycles; `mem_resp` appears in the request cycle.
- Clean miss: `mem_resp` 1 cycle after the FILL `pmem_resp`.
- Dirty miss: WB duration + FILL duration + 1 cycle.
- `pmem_read` and `pmem_write` are never both high.
- Each deasserts in the cycle after its `pmem_resp`, via the state change.
- Reset mid-operation: the next cycle is CHECK with all outputs 0. Pending pmem transfers are abandoned and metadata arrays clear on their own `rst`.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - Adds outputs `hit_cnt`, `miss_cnt` and `wb_cnt` (each `CNT_W` bits).
  - `hit_cnt` increments on CHECK hits that are not the post-FILL replay of a miss.
  - `miss_cnt` increments on CHECK→WB/FILL; `wb_cnt` increments on WB exit.
  - Counters saturate at all-ones and clear on `rst`.
- Undefined: the ports and logic are absent, and the control behaviour is identical.

## Structure
- Shared package `cache_types_pkg`: `cache_state_t` enum {CHECK, WB, FILL} and `localparam NUM_WAYS = 2`.
- Sub-module `cache_perf_ctr`: a single saturating counter with `clk`, `rst`, `inc` and `count`. It is instantiated three times, only under `CACHE_PERF_CNT_EN`.

## Test plan
- Reset, then read with `hit_way=2'b10` → same-cycle `mem_resp=1`, `out_way=1`, `lru_we=1`, `lru_din=0`, no `data_we`.
- Write with `hit_way=2'b01` → `data_we=2'b01`, `dirty_we=2'b01`, `dirty_din=1`, `mem_resp=1`, `lru_din=1`.
- Read miss, `lru_way=1`, `dirty_way=2'b00`, `pmem_resp` after 5 cycles → `pmem_read` high for 5 cycles. On the `pmem_resp` cycle: `data_we`, `tag_we` and `valid_we` = `2'b10`, `dirty_din=0`. Next cycle, with `hit_way=2'b10`, `mem_resp=1`.
- Write miss, `lru_way=0`, `dirty_way=2'b01` → `pmem_write` with `pmem_addr_sel=1` until `pmem_resp`, then `pmem_read` with `pmem_addr_sel=0`. After the fill, the replayed hit sets `dirty_we=2'b01`, `dirty_din=1`.
- `rst` asserted in the 2nd cycle of FILL → next cycle `pmem_read=0`, state CHECK, all outputs 0. A later `pmem_resp` pulse is ignored.
- With `CACHE_PERF_CNT_EN`: 3 hits, 1 clean miss, 1 dirty miss → `hit_cnt=3`, `miss_cnt=2`, `wb_cnt=1`.
